ps2_host_xmit: RTL and testbench

- Parametrised PS/2 host-to-device transmitter. Next generation of the team's single-byte PS/2 sender.
- Adds the following, none of which the current sender has:
  - clock-frequency-derived timing
  - metastability synchroniser
  - device-clock timeout
  - device ACK-bit check
  - automatic retry
  - busy/error reporting
- Sits between the keyboard/mouse command logic and the PS/2 pins. Shares PS2_CLK/PS2_DATA with the PS/2 receiver, which must ignore the bus while busy=1.

---
 rtl/ps2_host_xmit.sv | 219 +++++++++++++++++++++
 tb/tb_ps2_host_xmit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_xmit.sv
// ps2_host_xmit: PS/2 host-to-device byte transmitter.
// Sequence per attempt: inhibit the bus (CLK low), request-to-send
// (DATA low, CLK released), shift 8 data bits + odd parity + stop on the
// device's falling clock edges, then check the device ACK bit and wait
// for the bus to go idle. Failed attempts (no ACK or device-clock
// timeout) are retried up to MAX_RETRY times with the same byte.
// Ports:
//   clk_sys, rst_n         system clock, asynchronous active-low reset
//   PS2_CLK, PS2_DATA      open-drain bus lines (drive 0 or z only)
//   wr_en, wr_data         write request and byte, accepted when busy=0
//   busy                   transfer in progress (receiver must ignore bus)
//   wr_done, wr_err        one-cycle completion / failure pulses
//   err_code               01 = no ACK, 10 = timeout, held until next accept
module ps2_host_xmit #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int INHIBIT_US  = 200,
    parameter int TIMEOUT_US  = 15000,
    parameter int SYNC_STAGES = 3,
    parameter int MAX_RETRY   = 2
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DATA,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       wr_done,
    output logic       wr_err,
    output logic [1:0] err_code
);

    localparam int INH_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TO_CYC  = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int CNT_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INHIBIT = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_WAIT    = 3'd5;

    logic [2:0]             state_r;
    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [3:0]             bit_idx_r;
    logic [2:0]             retry_cnt_r;
    logic [7:0]             data_r;
    logic                   parity_r;
    logic                   drv_clk_r;
    logic                   drv_data_r;
    logic                   busy_r;
    logic                   wr_done_r;
    logic                   wr_err_r;
    logic [1:0]             err_code_r;

    logic                   clk_s;
    logic                   data_s;
    logic                   fe_s;
    logic                   timed_s;
    logic                   bus_idle_s;
    logic                   to_hit_s;
    logic                   nack_s;
    logic                   fail_s;
    logic [1:0]             fail_code_s;

    // Odd parity bit for a byte: set when the byte has an even number of ones.
    function automatic logic odd_parity(input logic [7:0] value);
        return ~(^value);
    endfunction

    // Open-drain drivers: only ever pull low, otherwise release.
    assign PS2_CLK  = drv_clk_r  ? 1'b0 : 1'bz;
    assign PS2_DATA = drv_data_r ? 1'b0 : 1'bz;

    assign busy     = busy_r;
    assign wr_done  = wr_done_r;
    assign wr_err   = wr_err_r;
    assign err_code = err_code_r;

    // Edge detect and failure qualification; an fe in the same cycle as the
    // timeout limit wins, and bus-idle in WAIT beats the timeout.
    always_comb begin
        clk_s       = clk_sync_r[SYNC_STAGES-1];
        data_s      = data_sync_r[SYNC_STAGES-1];
        fe_s        = clk_prev_r & ~clk_s;
        timed_s     = (state_r == ST_SHIFT) || (state_r == ST_ACK) || (state_r == ST_WAIT);
        bus_idle_s  = clk_s & data_s;
        if ((state_r == ST_WAIT) && bus_idle_s) begin
            to_hit_s = 1'b0;
        end else begin
            to_hit_s = timed_s && !fe_s && (cnt_r == CNT_W'(TO_CYC - 1));
        end
        nack_s      = (state_r == ST_ACK) && fe_s && data_s;
        fail_s      = to_hit_s || nack_s;
        fail_code_s = nack_s ? 2'b01 : 2'b10;
    end

    // Synchronisers, transfer FSM and all registered outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
            clk_prev_r  <= 1'b1;
            cnt_r       <= {CNT_W{1'b0}};
            bit_idx_r   <= 4'd0;
            retry_cnt_r <= 3'd0;
            data_r      <= 8'd0;
            parity_r    <= 1'b0;
            drv_clk_r   <= 1'b0;
            drv_data_r  <= 1'b0;
            busy_r      <= 1'b0;
            wr_done_r   <= 1'b0;
            wr_err_r    <= 1'b0;
            err_code_r  <= 2'b00;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], PS2_CLK};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], PS2_DATA};
            clk_prev_r  <= clk_s;
            wr_done_r   <= 1'b0;
            wr_err_r    <= 1'b0;
            if (fail_s) begin
                drv_data_r <= 1'b0;
                cnt_r      <= {CNT_W{1'b0}};
                if (retry_cnt_r < 3'(MAX_RETRY)) begin
                    // Go straight back to inhibit with the latched byte.
                    retry_cnt_r <= retry_cnt_r + 3'd1;
                    drv_clk_r   <= 1'b1;
                    state_r     <= ST_INHIBIT;
                end else begin
                    drv_clk_r  <= 1'b0;
                    wr_err_r   <= 1'b1;
                    err_code_r <= fail_code_s;
                    state_r    <= ST_IDLE;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        drv_clk_r  <= 1'b0;
                        drv_data_r <= 1'b0;
                        // busy_r still high here during the done/err pulse cycle.
                        busy_r     <= 1'b0;
                        if (wr_en && !busy_r) begin
                            data_r      <= wr_data;
                            parity_r    <= odd_parity(wr_data);
                            retry_cnt_r <= 3'd0;
                            err_code_r  <= 2'b00;
                            busy_r      <= 1'b1;
                            drv_clk_r   <= 1'b1;
                            cnt_r       <= {CNT_W{1'b0}};
                            state_r     <= ST_INHIBIT;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_INHIBIT: begin
                        if (cnt_r == CNT_W'(INH_CYC - 1)) begin
                            drv_clk_r  <= 1'b0;
                            drv_data_r <= 1'b1;
                            state_r    <= ST_REQ;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                    ST_REQ: begin
                        cnt_r     <= {CNT_W{1'b0}};
                        bit_idx_r <= 4'd0;
                        state_r   <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (fe_s) begin
                            cnt_r     <= {CNT_W{1'b0}};
                            bit_idx_r <= bit_idx_r + 4'd1;
                            if (bit_idx_r < 4'd8) begin
                                drv_data_r <= ~data_r[bit_idx_r[2:0]];
                            end else if (bit_idx_r == 4'd8) begin
                                drv_data_r <= ~parity_r;
                            end else begin
                                drv_data_r <= 1'b0;
                                state_r    <= ST_ACK;
                            end
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                    ST_ACK: begin
                        if (fe_s) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= ST_WAIT;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (bus_idle_s) begin
                            wr_done_r <= 1'b1;
                            state_r   <= ST_IDLE;
                        end else if (fe_s) begin
                            cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                    default: begin
                        drv_clk_r  <= 1'b0;
                        drv_data_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_xmit.sv
// Self-checking bench for ps2_host_xmit. A PS/2 device model clocks
// frames and ACKs/NACKs/ignores each attempt; a reference model derives
// the expected outcome (done/err, code, attempt and frame counts) from
// the per-attempt device behaviour. Expected responses go into a queue
// that an independent monitor pops on every wr_done/wr_err pulse.
module tb_ps2_host_xmit;

    localparam int P_CLK_HZ = 1_000_000;
    localparam int P_INH_US = 20;
    localparam int P_TO_US  = 300;
    localparam int P_RETRY  = 1;
    localparam int INH      = P_CLK_HZ / 1_000_000 * P_INH_US;
    localparam int TO       = P_CLK_HZ / 1_000_000 * P_TO_US;
    localparam int H        = 10;
    localparam int M_ACK    = 0;
    localparam int M_NACK   = 1;
    localparam int M_NOCLK  = 2;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       busy, wr_done, wr_err;
    logic [1:0] err_code;
    wire        ps2_clk, ps2_data;
    logic       dev_clk_drv  = 1'b0;
    logic       dev_data_drv = 1'b0;

    pullup (ps2_clk);
    pullup (ps2_data);
    assign ps2_clk  = dev_clk_drv  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_drv ? 1'b0 : 1'bz;

    ps2_host_xmit #(
        .CLK_HZ(P_CLK_HZ), .INHIBIT_US(P_INH_US), .TIMEOUT_US(P_TO_US),
        .SYNC_STAGES(3), .MAX_RETRY(P_RETRY)
    ) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .wr_done(wr_done),
        .wr_err(wr_err), .err_code(err_code)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
    } resp_t;

    resp_t exp_q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    inh_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: walk the attempts as the protocol rules dictate.
    function automatic void model(input int m0, input int m1, output bit is_err,
                                  output logic [1:0] code, output int attempts, output int frames);
        int modes[2];
        modes    = '{m0, m1};
        attempts = 0;
        frames   = 0;
        is_err   = 1'b1;
        code     = 2'b00;
        for (int i = 0; i <= P_RETRY; i++) begin
            attempts++;
            if (modes[i] != M_NOCLK) frames++;
            if (modes[i] == M_ACK) begin
                is_err = 1'b0;
                code   = 2'b00;
                return;
            end
            code = (modes[i] == M_NACK) ? 2'b01 : 2'b10;
        end
    endfunction

    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    // Response monitor: pops one expectation per completion pulse.
    bit    busy_fall_pending = 1'b0;
    resp_t mon_r;
    always @(negedge clk_sys) begin
        if (busy_fall_pending) begin
            chk("busy_fall_after_pulse", busy, 1'b0);
            busy_fall_pending = 1'b0;
        end
        if (rst_n && (wr_done || wr_err)) begin
            chk("busy_at_pulse", busy, 1'b1);
            busy_fall_pending = 1'b1;
            if (exp_q.size() == 0) begin
                bound_fail("unexpected_pulse");
            end else begin
                mon_r = exp_q.pop_front();
                chk("pulse_kind", {wr_done, wr_err}, mon_r.is_err ? 2'b01 : 2'b10);
                chk("err_code", err_code, mon_r.code);
            end
        end
    end

    // Inhibit monitor: every host-driven CLK-low run must be INH cycles with DATA released.
    int inh_run = 0;
    bit inh_data_ok = 1'b1;
    always @(negedge clk_sys) begin
        if (ps2_clk === 1'b0 && !dev_clk_drv) begin
            inh_run++;
            if (ps2_data !== 1'b1) inh_data_ok = 1'b0;
        end else if (inh_run > 0) begin
            chk("inhibit_len", inh_run, INH);
            chk("inhibit_data_released", inh_data_ok, 1'b1);
            inh_count++;
            inh_run     = 0;
            inh_data_ok = 1'b1;
        end
    end

    task automatic wait_rts(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0)) begin
            @(posedge clk_sys);
            #1;
            n++;
            if (n > INH + TO + 100) begin
                bound_fail("rts_wait");
                ok = 1'b0;
                return;
            end
        end
    endtask

    // Device side of one frame; abort_k>0 stops with CLK held low after that clock.
    task automatic dev_frame(input int mode, input int abort_k, output logic [9:0] bits);
        bit ok;
        bits = 10'd0;
        wait_rts(ok);
        if (!ok) return;
        repeat (5) @(posedge clk_sys);
        #1;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_drv = 1'b1;
            if (k == 11 && mode == M_ACK) dev_data_drv = 1'b1;
            repeat ((k == 11) ? 2 : H) @(posedge clk_sys);
            #1;
            if (k == abort_k) return;
            dev_clk_drv  = 1'b0;
            dev_data_drv = 1'b0;
            #1;
            if (k <= 10) bits[k-1] = ps2_data;
            repeat (H) @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic wait_not_busy();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk_sys);
            if (busy === 1'b0) return;
            n++;
            if (n > (P_RETRY + 1) * (INH + TO + 400)) begin
                bound_fail("busy_wait");
                return;
            end
        end
    endtask

    task automatic issue(input logic [7:0] b);
        @(posedge clk_sys);
        #1;
        chk("busy_before_accept", busy, 1'b0);
        chk("clk_released_before_accept", ps2_clk, 1'b1);
        wr_data = b;
        wr_en   = 1'b1;
        @(posedge clk_sys);
        #1;
        wr_en = 1'b0;
        chk("clk_low_one_cycle_after_accept", ps2_clk, 1'b0);
        chk("busy_after_accept", busy, 1'b1);
    endtask

    task automatic run_trx(input logic [7:0] b, input int m0, input int m1, input bit dup_wr);
        bit         is_err, ok;
        logic [1:0] code;
        int         attempts, frames, inh0, nframes, n;
        int         modes[2];
        logic [9:0] bits;
        resp_t      r;
        modes = '{m0, m1};
        model(m0, m1, is_err, code, attempts, frames);
        r.is_err = is_err;
        r.code   = code;
        exp_q.push_back(r);
        inh0    = inh_count;
        nframes = 0;
        issue(b);
        if (dup_wr) begin
            repeat (3) @(posedge clk_sys);
            #1;
            wr_data = ~b;
            wr_en   = 1'b1;
            @(posedge clk_sys);
            #1;
            wr_en = 1'b0;
        end
        for (int i = 0; i < attempts; i++) begin
            if (modes[i] == M_NOCLK) begin
                wait_rts(ok);
                n = 0;
                while (ok && ps2_clk === 1'b1 && busy === 1'b1) begin
                    @(posedge clk_sys);
                    #1;
                    n++;
                    if (n > TO + 50) begin
                        bound_fail("timeout_wait");
                        ok = 1'b0;
                    end
                end
            end else begin
                dev_frame(modes[i], 0, bits);
                chk("frame_bits", bits, frame_bits(b));
                nframes++;
            end
        end
        wait_not_busy();
        chk("queue_drained", exp_q.size(), 0);
        chk("attempt_count", inh_count - inh0, attempts);
        chk("frame_count", nframes, frames);
        chk("lines_released", {ps2_clk, ps2_data}, 2'b11);
        repeat (3) @(negedge clk_sys);
        chk("err_code_held", err_code, code);
        if (dup_wr) begin
            inh0 = inh_count;
            repeat ((P_RETRY + 1) * (INH + TO + 50)) @(negedge clk_sys);
            chk("dup_write_ignored", inh_count - inh0, 0);
            chk("dup_no_pending", exp_q.size(), 0);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk("reset_outputs", {busy, wr_done, wr_err, err_code}, 5'b0);
        chk("reset_lines", {ps2_clk, ps2_data}, 2'b11);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("idle_outputs", {busy, wr_done, wr_err, err_code}, 5'b0);

        run_trx(8'hED, M_ACK, M_ACK, 1'b0);
        run_trx(8'hF4, M_ACK, M_ACK, 1'b1);
        run_trx(8'h3C, M_NOCLK, M_NOCLK, 1'b0);
        run_trx(8'hA5, M_NACK, M_ACK, 1'b0);
        run_trx(8'h81, M_NACK, M_NACK, 1'b0);
        run_trx(8'h00, M_NOCLK, M_ACK, 1'b0);
        for (int t = 0; t < 6; t++) begin
            run_trx(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset while the host drives data bit 4 (0 for 0xED).
        issue(8'hED);
        dev_frame(M_ACK, 5, bits);
        dev_clk_drv = 1'b0;
        @(posedge clk_sys);
        #2;
        chk("data_bit4_driven", ps2_data, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_lines", {ps2_clk, ps2_data}, 2'b11);
        chk("async_reset_outputs", {busy, wr_done, wr_err, err_code}, 5'b0);
        repeat (3) @(posedge clk_sys);
        #3 rst_n = 1'b1;
        run_trx(8'hED, M_ACK, M_ACK, 1'b0);

        repeat (5) @(negedge clk_sys);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
